// File: rtl/snn_enc_pkg.sv
// ---------------------------------------------------------------------------
// snn_enc_pkg
// Shared types, constants and the pixel-to-spike-time encoder used by the
// spike_time_encoder slice.
//   spike_time_t : one spike time, LOG_TIME_PERIOD+1 bits wide
//   NO_SPIKE     : value meaning "this input does not fire this period"
//   enc_state_t  : fill-side FSM states
//   encode_pix() : intensity -> first-spike time (brighter fires earlier)
// ---------------------------------------------------------------------------
package snn_enc_pkg;

    localparam int unsigned ENC_NUM_INPUTS      = 16;
    localparam int unsigned ENC_PIX_W           = 8;
    localparam int unsigned ENC_TIME_PERIOD     = 8;
    localparam int unsigned ENC_LOG_TIME_PERIOD = 3;
    localparam int unsigned ENC_MIN_PIX         = 16;

    typedef logic [ENC_LOG_TIME_PERIOD:0] spike_time_t;

    localparam spike_time_t NO_SPIKE = spike_time_t'(ENC_TIME_PERIOD);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } enc_state_t;

    // Dim pixels never fire; otherwise the inverted intensity is scaled down
    // to the period range, so full brightness fires at step 0.
    function automatic spike_time_t encode_pix(input logic [ENC_PIX_W-1:0] pix);
        logic [ENC_PIX_W-1:0] inv;
        inv = ~pix;  // equals (2^PIX_W - 1) - pix
        if (pix < ENC_PIX_W'(ENC_MIN_PIX)) begin
            return NO_SPIKE;
        end
        return spike_time_t'(inv >> (ENC_PIX_W - ENC_LOG_TIME_PERIOD));
    endfunction

endpackage

// File: rtl/spike_fill_buffer.sv
// ---------------------------------------------------------------------------
// spike_fill_buffer
// Write-side frame buffer: an arrival-order index counter plus a
// NUM_INPUTS-entry array of encoded spike times.
//   clk_i     : clock
//   clear_i   : synchronous clear of the index (partial frame discarded)
//   wr_en_i   : store wr_data_i at the current index and advance
//   wr_data_i : encoded spike time
//   last_o    : index points at the final entry of the frame
//   buf_o     : all entries, entry i at [i*W +: W]
// ---------------------------------------------------------------------------
module spike_fill_buffer
    import snn_enc_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = ENC_NUM_INPUTS
) (
    input  logic                                     clk_i,
    input  logic                                     clear_i,
    input  logic                                     wr_en_i,
    input  spike_time_t                              wr_data_i,
    output logic                                     last_o,
    output logic [NUM_INPUTS*$bits(spike_time_t)-1:0] buf_o
);

    localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [IDX_W-1:0]               idx_q, idx_d;
    spike_time_t [NUM_INPUTS-1:0]   mem_q;

    assign last_o = (idx_q == IDX_W'(NUM_INPUTS - 1));
    assign buf_o  = mem_q;

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (wr_en_i) begin
            idx_d = last_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        idx_q <= idx_d;
        if (wr_en_i && !clear_i) begin
            mem_q[idx_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/spike_time_encoder.sv
// ---------------------------------------------------------------------------
// spike_time_encoder
// Accepts pixels over valid/ready, encodes them to first-spike times and
// presents one full frame to the layer per time period, switching only at
// the time_val wrap edge (time_val == TIME_PERIOD-1).
//   clk, rst_l         : clock, synchronous active-low reset
//   pix_valid/ready    : pixel stream handshake (pix_ready is registered)
//   pix_data           : pixel intensity, index given by arrival order
//   time_val           : shared period counter, input only
//   spike_times        : active frame, entry i at [i*(LOG+1) +: LOG+1]
//   frame_valid        : spike_times holds a real frame this period
//   frame_start        : one-cycle pulse as a new frame becomes active
// Optional (macro SPIKE_ENC_STATS_EN):
//   frames_committed   : saturating count of commits
//   periods_idle       : saturating count of wraps with no frame ready
// ---------------------------------------------------------------------------
module spike_time_encoder
    import snn_enc_pkg::*;
#(
    parameter int unsigned NUM_INPUTS      = ENC_NUM_INPUTS,
    parameter int unsigned PIX_W           = ENC_PIX_W,
    parameter int unsigned TIME_PERIOD     = ENC_TIME_PERIOD,
    parameter int unsigned LOG_TIME_PERIOD = ENC_LOG_TIME_PERIOD,
    parameter int unsigned MIN_PIX         = ENC_MIN_PIX
) (
    input  logic                                       clk,
    input  logic                                       rst_l,
    input  logic                                       pix_valid,
    output logic                                       pix_ready,
    input  logic [PIX_W-1:0]                           pix_data,
    input  logic [LOG_TIME_PERIOD:0]                   time_val,
    output logic [NUM_INPUTS*(LOG_TIME_PERIOD+1)-1:0]  spike_times,
    output logic                                       frame_valid,
    output logic                                       frame_start
`ifdef SPIKE_ENC_STATS_EN
    ,
    output logic [15:0]                                frames_committed,
    output logic [15:0]                                periods_idle
`endif
);

    localparam int unsigned FRAME_W = NUM_INPUTS * (LOG_TIME_PERIOD + 1);

    enc_state_t           state_q, state_d;
    logic                 pix_ready_q, pix_ready_d;
    logic [FRAME_W-1:0]   spike_times_q, spike_times_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 frame_start_q, frame_start_d;

    logic                 xfer;
    logic                 wrap;
    logic                 commit;
    logic                 buf_last;
    logic [FRAME_W-1:0]   fill_buf;

    assign xfer   = pix_valid && pix_ready_q;
    assign wrap   = (time_val == (LOG_TIME_PERIOD+1)'(TIME_PERIOD - 1));
    assign commit = (state_q == FULL) && wrap;

    spike_fill_buffer #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_fill (
        .clk_i     (clk),
        .clear_i   (!rst_l),
        .wr_en_i   (xfer),
        .wr_data_i (encode_pix(pix_data)),
        .last_o    (buf_last),
        .buf_o     (fill_buf)
    );

    // ---------------- fill FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- fill FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (xfer && buf_last) state_d = FULL;
            FULL: if (wrap)             state_d = FILL;
            default:                    state_d = FILL;
        endcase
    end

    // ---------------- fill FSM: outputs ----------------
    // Ready is computed from the next state so the registered copy lines up
    // with the state it describes.
    always_comb begin
        pix_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            pix_ready_q <= 1'b1;
        end else begin
            pix_ready_q <= pix_ready_d;
        end
    end

    assign pix_ready = pix_ready_q;

    // ---------------- presented frame ----------------
    // Outputs move only at the wrap edge; a wrap without a full frame blanks
    // the layer's inputs for the coming period.
    always_comb begin
        spike_times_d = spike_times_q;
        frame_valid_d = frame_valid_q;
        frame_start_d = 1'b0;
        if (wrap) begin
            if (state_q == FULL) begin
                spike_times_d = fill_buf;
                frame_valid_d = 1'b1;
                frame_start_d = 1'b1;
            end else begin
                spike_times_d = {NUM_INPUTS{NO_SPIKE}};
                frame_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            spike_times_q <= {NUM_INPUTS{NO_SPIKE}};
            frame_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            spike_times_q <= spike_times_d;
            frame_valid_q <= frame_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign spike_times = spike_times_q;
    assign frame_valid = frame_valid_q;
    assign frame_start = frame_start_q;

`ifdef SPIKE_ENC_STATS_EN
    logic [15:0] frames_committed_q, frames_committed_d;
    logic [15:0] periods_idle_q, periods_idle_d;

    always_comb begin
        frames_committed_d = frames_committed_q;
        periods_idle_d     = periods_idle_q;
        if (commit && (frames_committed_q != '1)) begin
            frames_committed_d = frames_committed_q + 16'd1;
        end
        if (wrap && !commit && (periods_idle_q != '1)) begin
            periods_idle_d = periods_idle_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            frames_committed_q <= '0;
            periods_idle_q     <= '0;
        end else begin
            frames_committed_q <= frames_committed_d;
            periods_idle_q     <= periods_idle_d;
        end
    end

    assign frames_committed = frames_committed_q;
    assign periods_idle     = periods_idle_q;
`endif

endmodule

// File: tb/tb_spike_time_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_time_encoder
// Bench for spike_time_encoder. Inputs (including time_val) are driven on
// the falling edge; outputs are sampled 1 ns after the rising edge and
// compared with a frame-level reference model. Stats ports are checked when
// SPIKE_ENC_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_spike_time_encoder;

    localparam int N  = 16;
    localparam int TP = 8;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [3:0]  time_val;
    logic [63:0] spike_times;
    logic        frame_valid;
    logic        frame_start;
`ifdef SPIKE_ENC_STATS_EN
    logic [15:0] frames_committed;
    logic [15:0] periods_idle;
`endif

    always #5 clk = ~clk;

    spike_time_encoder dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .time_val    (time_val),
        .spike_times (spike_times),
        .frame_valid (frame_valid),
        .frame_start (frame_start)
`ifdef SPIKE_ENC_STATS_EN
        ,
        .frames_committed (frames_committed),
        .periods_idle     (periods_idle)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model state ----------------
    int          tv = 0;          // time_val to be presented in the next cycle
    logic [3:0]  fill_q[$];       // encoded times of the frame being filled
    logic [63:0] m_pend;          // completed frame awaiting the wrap
    bit          m_full;
    logic [63:0] m_out;
    bit          m_valid;
    bit          m_start;
    int          m_commits;
    int          m_idle;
    bit          last_acc;

    localparam logic [63:0] ALL_NO_SPIKE = {16{4'd8}};

    function automatic logic [3:0] ref_encode(input int p);
        if (p < 16) return 4'd8;
        return 4'((255 - p) / 32);
    endfunction

    // One clock cycle: drive inputs, then advance the model at the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit rst);
        @(negedge clk);
        rst_l     = !rst;
        pix_valid = v;
        pix_data  = d;
        time_val  = 4'(tv);
        @(posedge clk);
        if (rst) begin
            fill_q.delete();
            m_full = 0; m_out = ALL_NO_SPIKE; m_valid = 0; m_start = 0;
            m_commits = 0; m_idle = 0; last_acc = 0;
        end else begin
            last_acc = v && !m_full;
            m_start  = 0;
            if (tv == TP - 1) begin
                if (m_full) begin
                    m_out = m_pend; m_valid = 1; m_start = 1; m_full = 0;
                    if (m_commits < 65535) m_commits++;
                end else begin
                    m_out = ALL_NO_SPIKE; m_valid = 0;
                    if (m_idle < 65535) m_idle++;
                end
            end
            if (last_acc) begin
                fill_q.push_back(ref_encode(int'(d)));
                if (fill_q.size() == N) begin
                    for (int i = 0; i < N; i++) m_pend[i*4 +: 4] = fill_q[i];
                    fill_q.delete();
                    m_full = 1;
                end
            end
        end
        tv = (tv + 1) % TP;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit seen_start = 0;
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        n_tests++;
        if ({pix_ready, frame_valid, frame_start, spike_times} !== {1'b1, 1'b0, 1'b0, ALL_NO_SPIKE}) begin
            n_fail++;
            $display("FAIL reset_state got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {1'b1, 1'b0, 1'b0, ALL_NO_SPIKE});
        end
        for (int k = 0; k < 3 * TP; k++) begin
            step(0, 8'($urandom), 0);
            if (frame_start === 1'b1) seen_start = 1;
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL reset_idle_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
        end
        n_tests++;
        if (seen_start || pix_ready !== 1'b1 || frame_valid !== 1'b0 || spike_times !== ALL_NO_SPIKE) begin
            n_fail++;
            $display("FAIL reset_idle_end start_seen=%0b ready=%b valid=%b times=%h required ready=1 valid=0 times=%h", seen_start, pix_ready, frame_valid, spike_times, ALL_NO_SPIKE);
        end
    endtask

    task automatic test_encoding();
        int px[6] = '{255, 128, 16, 15, 0, 200};
        logic [23:0] exp_first = {4'd1, 4'd8, 4'd8, 4'd7, 4'd3, 4'd0};
        bit got = 0;
        for (int i = 0; i < N; i++) begin
            step(1, (i < 6) ? 8'(px[i]) : 8'($urandom), 0);
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL encode_fill_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
        end
        for (int k = 0; k < 3 * TP && !got; k++) begin
            step(0, 8'h00, 0);
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL encode_wait_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
            if (frame_start === 1'b1) got = 1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL encode_commit_timeout frame_start=0 required=1");
        end
        n_tests++;
        if (spike_times[23:0] !== exp_first || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL encode_values got=%h valid=%b required=%h valid=1", spike_times[23:0], frame_valid, exp_first);
        end
        n_tests++;
        if (tv != 0) begin
            n_fail++;
            $display("FAIL encode_start_phase time_val=%0d required=0", tv);
        end
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int starts   = 0;
        int hold     = 0;
        for (int k = 0; k < 100 && starts < 2; k++) begin
            step(accepted < 2 * N, 8'($urandom), 0);
            if (last_acc) accepted++;
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL b2b_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
            if (frame_start === 1'b1) starts++;
            if (starts == 1 && frame_valid === 1'b1) hold++;
        end
        n_tests++;
        if (starts != 2 || accepted != 2 * N) begin
            n_fail++;
            $display("FAIL b2b_timeout starts=%0d accepted=%0d required starts=2 accepted=%0d", starts, accepted, 2 * N);
        end
        n_tests++;
        if (hold != TP) begin
            n_fail++;
            $display("FAIL b2b_hold frame_a_cycles=%0d required=%0d", hold, TP);
        end
    endtask

    task automatic test_starvation();
        for (int k = 0; k < TP; k++) begin
            step(0, 8'h00, 0);
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL starve_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
        end
        n_tests++;
        if (frame_valid !== 1'b0 || spike_times !== ALL_NO_SPIKE) begin
            n_fail++;
            $display("FAIL starve_blank valid=%b times=%h required valid=0 times=%h", frame_valid, spike_times, ALL_NO_SPIKE);
        end
    endtask

    task automatic test_boundary(input int last_tv, input int exp_lat);
        int  lat = 0;
        bit  got = 0;
        for (int i = 0; i < N - 1; i++) step(1, 8'($urandom), 0);
        for (int k = 0; k < TP && tv != last_tv; k++) begin
            step(0, 8'h00, 0);
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL boundary_wait_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
        end
        step(1, 8'($urandom_range(16, 255)), 0);
        n_tests++;
        if (!last_acc || !m_full) begin
            n_fail++;
            $display("FAIL boundary_last_accept accepted=%0b frame_done=%0b required 1 1", last_acc, m_full);
        end
        for (int k = 0; k < 3 * TP && !got; k++) begin
            step(0, 8'h00, 0);
            lat = k + 2;
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL boundary_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
            if (frame_start === 1'b1) got = 1;
        end
        n_tests++;
        if (!got || lat != exp_lat) begin
            n_fail++;
            $display("FAIL boundary_latency_tv%0d got=%0d required=%0d", last_tv, got ? lat : -1, exp_lat);
        end
    endtask

    task automatic test_reset_midfill();
        bit got = 0;
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0);
        step(0, 8'h00, 1);
        n_tests++;
        if ({pix_ready, frame_valid, frame_start, spike_times} !== {1'b1, 1'b0, 1'b0, ALL_NO_SPIKE}) begin
            n_fail++;
            $display("FAIL midfill_reset got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {1'b1, 1'b0, 1'b0, ALL_NO_SPIKE});
        end
`ifdef SPIKE_ENC_STATS_EN
        n_tests++;
        if (frames_committed !== 16'd0 || periods_idle !== 16'd0) begin
            n_fail++;
            $display("FAIL midfill_stats_reset commits=%0d idle=%0d required 0 0", frames_committed, periods_idle);
        end
`endif
        for (int i = 0; i < N; i++) step(1, 8'($urandom), 0);
        for (int k = 0; k < 3 * TP && !got; k++) begin
            step(0, 8'h00, 0);
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL midfill_cycle got=%h required=%h", {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
            if (frame_start === 1'b1) got = 1;
        end
        n_tests++;
        if (!got || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midfill_commit start_seen=%0b valid=%b required 1 1", got, frame_valid);
        end
`ifdef SPIKE_ENC_STATS_EN
        n_tests++;
        if (frames_committed !== 16'd1 || periods_idle !== 16'(m_idle)) begin
            n_fail++;
            $display("FAIL midfill_stats commits=%0d idle=%0d required 1 %0d", frames_committed, periods_idle, m_idle);
        end
`endif
    endtask

    task automatic test_random();
        int pick;
        logic [7:0] d;
        for (int k = 0; k < 400; k++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0:       d = 8'd15;
                1:       d = 8'd16;
                2:       d = 8'd255;
                default: d = 8'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 199) == 0);
            n_tests++;
            if ({pix_ready, frame_valid, frame_start, spike_times} !== {!m_full, m_valid, m_start, m_out}) begin
                n_fail++;
                $display("FAIL random_cycle k=%0d got=%h required=%h", k, {pix_ready, frame_valid, frame_start, spike_times}, {!m_full, m_valid, m_start, m_out});
            end
`ifdef SPIKE_ENC_STATS_EN
            n_tests++;
            if (frames_committed !== 16'(m_commits) || periods_idle !== 16'(m_idle)) begin
                n_fail++;
                $display("FAIL random_stats k=%0d commits=%0d idle=%0d required %0d %0d", k, frames_committed, periods_idle, m_commits, m_idle);
            end
`endif
        end
    endtask

    initial begin
        rst_l     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        time_val  = 4'd0;
        test_reset();
        test_encoding();
        test_back_to_back();
        test_starvation();
        test_boundary(6, 2);
        test_boundary(7, 9);
        test_reset_midfill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
